// File: rtl/dual_core_ram_arbiter_pkg.sv
// Shared types for the dual-core RAM arbiter: RAM word/state types,
// the grant FSM states and the core index type.
`timescale 1ns/1ps
package dual_core_ram_arbiter_pkg;

    localparam int CPUS   = 2;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // RAM status as reported by the memory model / controller.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Grant FSM. Prefixed to stay distinct from the ramstate_t BUSY literal.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef logic [$clog2(CPUS)-1:0] core_idx_t;

    // One-hot mask selecting a single core lane.
    function automatic logic [CPUS-1:0] core_onehot(input core_idx_t c);
        logic [CPUS-1:0] m;
        m    = '0;
        m[c] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/dual_core_ram_arbiter_if.sv
// Bus bundle between the two cores, the arbiter and the RAM port.
//
// Handshake: a core raises iREN or dREN/dWEN together with its address
// (and write data) and holds them steady until the matching wait output
// is low. Wait low lasts exactly one cycle and marks completion; read
// data on iload/dload is valid in that same cycle. Dropping the request
// before completion abandons the access without a wait pulse.
`timescale 1ns/1ps
interface dual_core_ram_arbiter_if;
    import dual_core_ram_arbiter_pkg::*;

    // Core side
    logic  [CPUS-1:0] iREN;
    logic  [CPUS-1:0] dREN;
    logic  [CPUS-1:0] dWEN;
    word_t [CPUS-1:0] iaddr;
    word_t [CPUS-1:0] daddr;
    word_t [CPUS-1:0] dstore;
    logic  [CPUS-1:0] iwait;
    logic  [CPUS-1:0] dwait;
    word_t [CPUS-1:0] iload;
    word_t [CPUS-1:0] dload;

    // RAM side
    ramstate_t ramstate;
    word_t     ramload;
    word_t     ramaddr;
    word_t     ramstore;
    logic      ramREN;
    logic      ramWEN;

    // Environment view: cores issuing requests and the RAM answering.
    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
        input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
    );

    // Arbiter view.
    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
        output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
    );

endinterface

// File: rtl/dual_core_ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: with both requesters active
// the one that was not served last wins, otherwise the lone requester.
`timescale 1ns/1ps
module dual_core_ram_arbiter_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    // Pick the winner from the request pair and the last-served index.
    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        if (req[0] && req[1]) begin
            gnt = ~last;
        end else if (req[1]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/dual_core_ram_arbiter.sv
// Shares one RAM port between two cores, each with an instruction read
// port and a data read/write port. A registered grant is taken in IDLE
// (data beats instruction inside a core, round-robin across cores) and
// held in BUSY until the RAM reports ACCESS or the request is withdrawn.
`timescale 1ns/1ps
module dual_core_ram_arbiter
    import dual_core_ram_arbiter_pkg::*;
(
    input  logic                    CLK,
    input  logic                    nRST,
    dual_core_ram_arbiter_if.slave  bus,
    output arb_state_t              dbg_state
);

    arb_state_t       state, state_nxt;
    core_idx_t        last_core;
    core_idx_t        gnt_core;
    logic             gnt_is_data;

    logic [CPUS-1:0]  d_req;
    logic [CPUS-1:0]  any_req;
    logic             pick;
    logic             pick_valid;
    logic             load_gnt;
    logic             complete;
    logic             src_active;

    assign d_req     = bus.dREN | bus.dWEN;
    assign any_req   = d_req | bus.iREN;
    assign dbg_state = state;

    // Read data fans out to every lane; only the granted wait qualifies it.
    assign bus.iload = {CPUS{bus.ramload}};
    assign bus.dload = {CPUS{bus.ramload}};

    dual_core_ram_arbiter_rr_pick2 u_pick (
        .req   (any_req),
        .last  (last_core),
        .gnt   (pick),
        .valid (pick_valid)
    );

    // Grant register, last-served core and FSM state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= ARB_IDLE;
            last_core   <= core_idx_t'(1);
            gnt_core    <= '0;
            gnt_is_data <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_gnt) begin
                gnt_core    <= core_idx_t'(pick);
                gnt_is_data <= d_req[pick];
            end
            if (complete) begin
                last_core <= gnt_core;
            end
        end
    end

    // Next state, RAM drive and wait release for the current grant.
    always_comb begin
        state_nxt    = state;
        load_gnt     = 1'b0;
        complete     = 1'b0;
        src_active   = 1'b0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    load_gnt  = 1'b1;
                    state_nxt = ARB_BUSY;
                end
            end

            ARB_BUSY: begin
                src_active = gnt_is_data ? d_req[gnt_core] : bus.iREN[gnt_core];
                if (!src_active) begin
                    // Withdrawn: abandon quietly, fairness history untouched.
                    state_nxt = ARB_IDLE;
                end else begin
                    bus.ramaddr  = gnt_is_data ? bus.daddr[gnt_core] : bus.iaddr[gnt_core];
                    bus.ramstore = bus.dstore[gnt_core];
                    // A write wins over a read issued in the same cycle.
                    bus.ramWEN   = gnt_is_data & bus.dWEN[gnt_core];
                    bus.ramREN   = gnt_is_data ? (bus.dREN[gnt_core] & ~bus.dWEN[gnt_core])
                                               : bus.iREN[gnt_core];
                    if (bus.ramstate == ACCESS) begin
                        complete  = 1'b1;
                        state_nxt = ARB_IDLE;
                        if (gnt_is_data) begin
                            bus.dwait = ~core_onehot(gnt_core);
                        end else begin
                            bus.iwait = ~core_onehot(gnt_core);
                        end
                    end
                end
            end

            default: state_nxt = ARB_IDLE;
        endcase
    end

endmodule
